// File: rtl/riscv_trace_buffer_if.sv
// Drain port of the trace buffer: head entry fields plus a valid/ready handshake.
// valid/ready: out_valid stays high while an entry is present; an entry moves on a cycle where out_valid && out_ready.
interface riscv_trace_buffer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int TS_W   = 16
);
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        out_flags;
  logic [4:0]        out_reg_num;
  logic [DATA_W-1:0] out_reg_data;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_mem_data;
  logic [TS_W-1:0]   out_ts;

  modport master (
    output out_valid, out_flags, out_reg_num, out_reg_data, out_addr, out_mem_data, out_ts,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_flags, out_reg_num, out_reg_data, out_addr, out_mem_data, out_ts,
    output out_ready
  );
endinterface

// File: rtl/riscv_trace_buffer.sv
// Timestamped circular trace buffer for the core's writeback and data-memory trace,
// with stop-when-full or overwrite-oldest capture and a valid/ready drain port.
module riscv_trace_buffer #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 9,
  parameter int DEPTH     = 16,
  parameter int TS_W      = 16,
  parameter int WRAP_MODE = 0,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic              halt,
  input  logic              reg_write_sig,
  input  logic [4:0]        reg_num,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] rd_data,
  riscv_trace_buffer_if.master drain,
  output logic [CW-1:0]     count,
  output logic [1:0]        state,
  output logic              overrun,
  output logic              dropped
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CAPTURE = 2'd1, S_FROZEN = 2'd2} state_t;

  localparam int EW = 3 + 5 + DATA_W + ADDR_W + DATA_W + TS_W;

  state_t          cur, nxt;
  logic [PW-1:0]   head, tail;
  logic [TS_W-1:0] ts;
  logic [EW-1:0]   mem [DEPTH];
  logic [EW-1:0]   new_entry, head_entry;
  logic            ev, pop, full, push, drop, ovr, adv;
  logic [CW-1:0]   cnt_nxt;

  assign state = cur;
  assign full  = (count == CW'(DEPTH));
  assign ev    = (cur == S_CAPTURE) && (reg_write_sig || wr || rd);
  assign pop   = drain.out_valid && drain.out_ready;
  // A full buffer with a same-cycle pop has room, so only an unpopped full push drops or overwrites.
  assign drop  = ev && full && !pop && (WRAP_MODE == 0);
  assign ovr   = ev && full && !pop && (WRAP_MODE != 0);
  assign push  = ev && !drop;
  assign adv   = pop || ovr;

  assign new_entry = {reg_write_sig, wr, rd,
                      reg_write_sig ? reg_num  : 5'd0,
                      reg_write_sig ? reg_data : {DATA_W{1'b0}},
                      (wr || rd)    ? addr     : {ADDR_W{1'b0}},
                      wr ? wr_data : (rd ? rd_data : {DATA_W{1'b0}}),
                      ts};

  always_comb begin
    nxt = cur;
    if (clear) begin
      nxt = S_IDLE;
    end else begin
      case (cur)
        S_IDLE:    if (enable) nxt = S_CAPTURE;
        S_CAPTURE: if (halt || drop) nxt = S_FROZEN;
        S_FROZEN:  nxt = S_FROZEN;
        default:   nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_nxt = count;
    if (push && !adv)      cnt_nxt = count + CW'(1);
    else if (!push && adv) cnt_nxt = count - CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur     <= S_IDLE;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      ts      <= '0;
      overrun <= 1'b0;
      dropped <= 1'b0;
    end else if (clear) begin
      cur     <= S_IDLE;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      ts      <= '0;
      overrun <= 1'b0;
      dropped <= 1'b0;
    end else begin
      cur   <= nxt;
      ts    <= ts + TS_W'(1);
      count <= cnt_nxt;
      if (push) tail <= tail + PW'(1);
      if (adv)  head <= head + PW'(1);
      if (ovr)  overrun <= 1'b1;
      if (drop) dropped <= 1'b1;
    end
  end

  // Storage needs no reset: outputs are masked while count is zero.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[tail] <= new_entry;
  end

  assign drain.out_valid = (count != '0);
  assign head_entry      = drain.out_valid ? mem[head] : '0;
  assign {drain.out_flags, drain.out_reg_num, drain.out_reg_data,
          drain.out_addr, drain.out_mem_data, drain.out_ts} = head_entry;

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Bench for riscv_trace_buffer: a stop-mode and a wrap-mode instance (DEPTH=4) share
// the same trace stimulus and are compared every cycle against queue-based models.
module tb_riscv_trace_buffer;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [2:0]  flags;
    logic [4:0]  rn;
    logic [31:0] rdat;
    logic [8:0]  a;
    logic [31:0] md;
    logic [15:0] ts;
  } ent_t;

  logic clk, reset, enable, clear, halt;
  logic reg_write_sig, wr, rd;
  logic [4:0]  reg_num;
  logic [31:0] reg_data, wr_data, rd_data;
  logic [8:0]  addr;
  logic [2:0]  cnt0, cnt1;
  logic [1:0]  st0, st1;
  logic        ovr0, ovr1, drp0, drp1;

  riscv_trace_buffer_if if0 ();
  riscv_trace_buffer_if if1 ();

  riscv_trace_buffer #(.DEPTH(DEPTH), .WRAP_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .halt(halt),
    .reg_write_sig(reg_write_sig), .reg_num(reg_num), .reg_data(reg_data),
    .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
    .drain(if0.master), .count(cnt0), .state(st0), .overrun(ovr0), .dropped(drp0));

  riscv_trace_buffer #(.DEPTH(DEPTH), .WRAP_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .halt(halt),
    .reg_write_sig(reg_write_sig), .reg_num(reg_num), .reg_data(reg_data),
    .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
    .drain(if1.master), .count(cnt1), .state(st1), .overrun(ovr1), .dropped(drp1));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  ent_t        q0[$], q1[$];
  int          m_state [2];
  bit          m_ovr [2], m_drp [2];
  logic [15:0] ts_m;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t cur_entry();
    ent_t e;
    e.flags = {reg_write_sig, wr, rd};
    e.rn    = reg_write_sig ? reg_num : 5'd0;
    e.rdat  = reg_write_sig ? reg_data : 32'd0;
    e.a     = (wr || rd) ? addr : 9'd0;
    e.md    = wr ? wr_data : (rd ? rd_data : 32'd0);
    e.ts    = ts_m;
    return e;
  endfunction

  task automatic model_step(input int k, input bit rdy, input ent_t e,
                            input ent_t qi[$], output ent_t qo[$]);
    bit ev, pop, full;
    qo = qi;
    if (clear) begin
      qo.delete();
      m_state[k] = 0; m_ovr[k] = 0; m_drp[k] = 0;
      return;
    end
    ev   = (m_state[k] == 1) && (reg_write_sig || wr || rd);
    full = (qo.size() == DEPTH);
    pop  = (qo.size() > 0) && rdy;
    if (pop) void'(qo.pop_front());
    if (ev) begin
      if (full && !pop) begin
        if (k == 1) begin
          void'(qo.pop_front());
          qo.push_back(e);
          m_ovr[k] = 1;
        end else begin
          m_drp[k] = 1;
          m_state[k] = 2;
        end
      end else begin
        qo.push_back(e);
      end
    end
    if (m_state[k] == 0 && enable) m_state[k] = 1;
    else if (m_state[k] == 1 && halt) m_state[k] = 2;
  endtask

  task automatic model_reset();
    q0.delete(); q1.delete();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0; m_ovr[k] = 0; m_drp[k] = 0;
    end
    ts_m = '0;
  endtask

  task automatic chk_inst(input int k, input logic [2:0] cnt, input logic [1:0] st,
                          input logic ovr, input logic drp, input logic vld,
                          input logic [2:0] fl, input logic [4:0] rn_o, input logic [31:0] rdo,
                          input logic [8:0] ao, input logic [31:0] mdo, input logic [15:0] tso,
                          input ent_t qm[$]);
    ent_t e;
    e = '0;
    if (qm.size() > 0) e = qm[0];
    chk($sformatf("count%0d", k), cnt, qm.size());
    chk($sformatf("state%0d", k), st, m_state[k]);
    chk($sformatf("overrun%0d", k), ovr, m_ovr[k]);
    chk($sformatf("dropped%0d", k), drp, m_drp[k]);
    chk($sformatf("valid%0d", k), vld, qm.size() > 0);
    chk($sformatf("flags%0d", k), fl, e.flags);
    chk($sformatf("reg_num%0d", k), rn_o, e.rn);
    chk($sformatf("reg_data%0d", k), rdo, e.rdat);
    chk($sformatf("addr%0d", k), ao, e.a);
    chk($sformatf("mem_data%0d", k), mdo, e.md);
    chk($sformatf("ts%0d", k), tso, e.ts);
  endtask

  task automatic check_all();
    chk_inst(0, cnt0, st0, ovr0, drp0, if0.out_valid, if0.out_flags, if0.out_reg_num,
             if0.out_reg_data, if0.out_addr, if0.out_mem_data, if0.out_ts, q0);
    chk_inst(1, cnt1, st1, ovr1, drp1, if1.out_valid, if1.out_flags, if1.out_reg_num,
             if1.out_reg_data, if1.out_addr, if1.out_mem_data, if1.out_ts, q1);
  endtask

  // driver tasks
  task automatic cycle();
    ent_t e;
    @(posedge clk);
    e = cur_entry();
    model_step(0, if0.out_ready, e, q0, q0);
    model_step(1, if1.out_ready, e, q1, q1);
    ts_m = clear ? 16'd0 : ts_m + 16'd1;
    #1;
    check_all();
  endtask

  task automatic quiet();
    enable = 0; clear = 0; halt = 0;
    reg_write_sig = 0; wr = 0; rd = 0;
    if0.out_ready = 0; if1.out_ready = 0;
  endtask

  task automatic set_ev(input logic v, input logic w, input logic r, input logic [4:0] n,
                        input logic [31:0] d, input logic [8:0] a, input logic [31:0] wd,
                        input logic [31:0] rdd);
    reg_write_sig = v; wr = w; rd = r; reg_num = n; reg_data = d;
    addr = a; wr_data = wd; rd_data = rdd;
  endtask

  task automatic rand_ev();
    set_ev(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           5'($urandom), $urandom, 9'($urandom), $urandom, $urandom);
  endtask

  task automatic restart();
    quiet(); clear = 1; cycle();
    quiet(); enable = 1; cycle();
    quiet();
  endtask

  task automatic drain_all();
    quiet(); if0.out_ready = 1; if1.out_ready = 1;
    repeat (DEPTH + 1) cycle();
    quiet();
  endtask

  initial begin
    reg_num = 0; reg_data = 0; addr = 0; wr_data = 0; rd_data = 0;
    quiet();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    model_reset();
    check_all();
    chk("reset_count", cnt0, 0);
    chk("reset_state", st0, 0);

    // basic capture: rv, mw, mr then halt
    enable = 1; cycle(); quiet();
    set_ev(1, 0, 0, 5, 32'hDEADBEEF, 0, 0, 0); cycle();
    set_ev(0, 1, 0, 0, 0, 9'h10, 32'h11, 0); cycle();
    set_ev(0, 0, 1, 0, 0, 9'h20, 0, 32'h22); cycle();
    quiet(); halt = 1; cycle(); quiet();
    chk("basic_state", st0, 2);
    chk("basic_count", cnt0, 3);
    chk("basic_head_flags", if0.out_flags, 3'b100);
    drain_all();
    chk("basic_drained_valid", if0.out_valid, 0);

    // combined event in one cycle
    restart();
    set_ev(1, 1, 1, 1, 32'hA, 9'h4, 32'hB, 32'hC); cycle(); quiet();
    chk("comb_flags", if0.out_flags, 3'b111);
    chk("comb_mem_data", if0.out_mem_data, 32'hB);
    drain_all();

    // six events without pop: stop instance drops on the fifth, wrap instance overwrites
    restart();
    for (int i = 0; i < 6; i++) begin
      set_ev(1, 0, 0, 5'(i + 1), 32'(i + 1), 0, 0, 0);
      cycle();
      if (i == 4) begin
        chk("stop_dropped", drp0, 1);
        chk("stop_state", st0, 2);
      end
    end
    quiet();
    chk("stop_count", cnt0, 4);
    chk("stop_head", if0.out_reg_num, 1);
    chk("wrap_count", cnt1, 4);
    chk("wrap_overrun", ovr1, 1);
    chk("wrap_state", st1, 1);
    chk("wrap_head", if1.out_reg_num, 3);
    drain_all();

    // full buffer with simultaneous push and pop
    restart();
    for (int i = 0; i < 4; i++) begin
      set_ev(0, 1, 0, 0, 0, 9'(i), 32'(i + 100), 0); cycle();
    end
    set_ev(0, 1, 0, 0, 0, 9'h1F, 32'h1F, 0);
    if0.out_ready = 1; if1.out_ready = 1;
    chk("pp_pre_head", if0.out_addr, 0);
    cycle(); quiet();
    chk("pp_count", cnt0, 4);
    chk("pp_dropped", drp0, 0);
    chk("pp_overrun", ovr1, 0);
    chk("pp_new_head", if0.out_addr, 1);

    // async reset mid-capture
    restart();
    for (int i = 0; i < 3; i++) begin
      rand_ev(); reg_write_sig = 1; cycle();
    end
    quiet();
    #2 reset = 1;
    #1;
    chk("areset_count", cnt0, 0);
    chk("areset_state", st1, 0);
    chk("areset_valid", if0.out_valid, 0);
    #1 reset = 0;
    model_reset();
    check_all();

    // clear while frozen with dropped set, then timestamp restarts from zero
    enable = 1; cycle(); quiet();
    for (int i = 0; i < 5; i++) begin
      rand_ev(); wr = 1; cycle();
    end
    quiet();
    chk("frz_dropped", drp0, 1);
    clear = 1; cycle(); quiet();
    chk("clr_state", st0, 0);
    chk("clr_dropped", drp0, 0);
    chk("clr_overrun", ovr1, 0);
    enable = 1; cycle(); quiet();
    rand_ev(); rd = 1; cycle(); quiet();
    chk("clr_ts", if0.out_ts, 1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_ev();
      enable = ($urandom_range(0, 3) == 0);
      halt   = ($urandom_range(0, 39) == 0);
      clear  = ($urandom_range(0, 49) == 0);
      if0.out_ready = ($urandom_range(0, 2) == 0);
      if1.out_ready = ($urandom_range(0, 2) == 0);
      cycle();
    end
    quiet();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/riscv_trace_buffer.md
# riscv_trace_buffer

Parametrised trace-capture unit for the pipelined RISC-V core. It samples the core's writeback trace (`reg_num`/`reg_data`/`reg_write_sig`) and data-memory trace (`wr`/`rd`/`addr`/`wr_data`/`rd_data`) into a timestamped DEPTH-entry circular buffer. Capture freezes on halt or buffer full, and software or a bench drains the buffer over a valid/ready port. It sits beside the core top and replaces ad-hoc bench monitoring with on-chip, configurable-depth, stop-or-wrap trace.

## Interface
- `DATA_W`, 32: data width of register and memory values.
- `ADDR_W`, 9: data-memory address width.
- `DEPTH`, 16: entries; power of two, ≥2.
- `TS_W`, 16: timestamp width.
- `WRAP_MODE`, 0: 0 = stop when full; 1 = overwrite oldest.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `enable` in 1: arms capture (IDLE→CAPTURE).
- `clear` in 1: synchronous flush to IDLE; flags, pointers and timestamp cleared.
- `halt` in 1: core halt indication.
- `reg_write_sig` in 1, `reg_num` in 5, `reg_data` in DATA_W: writeback trace.
- `wr` in 1, `rd` in 1, `addr` in ADDR_W, `wr_data` in DATA_W, `rd_data` in DATA_W: memory trace.
- `out_ready` in 1: consumer accepts the head entry.
- `out_valid` out 1: head entry present (count>0).
- `out_flags` out 3: {rv, mw, mr} of head entry.
- `out_reg_num` out 5, `out_reg_data` out DATA_W, `out_addr` out ADDR_W, `out_mem_data` out DATA_W, `out_ts` out TS_W: head entry fields.
- `count` out $clog2(DEPTH+1): occupied entries.
- `state` out 2: 0 IDLE, 1 CAPTURE, 2 FROZEN.
- `overrun` out 1: sticky; an entry was overwritten (WRAP_MODE=1).
- `dropped` out 1: sticky; an event was discarded while full (WRAP_MODE=0).

## Operation
- Event cycle: in CAPTURE, with any of `reg_write_sig`, `wr`, `rd` high. Cycles with no event store nothing.
- One entry per event cycle:
  - Flags rv=`reg_write_sig`, mw=`wr`, mr=`rd`.
  - Reg fields are zero when rv=0. Addr and mem_data are zero when mw=mr=0.
  - mem_data = `wr_data` if `wr`, else `rd_data`.
  - ts = timestamp counter value in that cycle.
- Timestamp counter: reset 0; increments every cycle in any state; wraps at 2^TS_W; cleared by `clear`.
- State machine:
  - IDLE→CAPTURE when `enable`=1.
  - CAPTURE→FROZEN on `halt`=1; the halt cycle's event is still captured.
  - CAPTURE→FROZEN, WRAP_MODE=0: when an event arrives with count=DEPTH and no simultaneous pop. That event is discarded and `dropped` is set.
  - FROZEN→IDLE only on `clear`. `enable` is ignored outside IDLE.
  - `clear` in any state, including the same cycle as `enable`, gives IDLE.
- Pop: `out_valid`&&`out_ready` advances head and decrements count. Allowed in every state.
- Push and pop in the same cycle: both take effect and count is unchanged. When full, this is neither drop nor overrun.
- Push when full, no pop, WRAP_MODE=1: the oldest entry is overwritten, head advances, count stays DEPTH, `overrun` is set.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH.
- Pop with count=0 is ignored.

## Timing
- Reset values (async assert; release synchronous to `clk`):
  - state=IDLE, count=0, head/tail=0, ts=0.
  - `overrun`=`dropped`=0, `out_valid`=0.
  - Entry outputs are 0 while count=0.
- Capture latency: an event sampled at edge N appears in `count` after edge N. If the buffer was empty, it is on `out_*` with `out_valid`=1 in cycle N+1.
- Head outputs are combinational from storage at the head pointer. No extra read latency.
- `clear` and `reset` asserted mid-capture or mid-drain discard all entries immediately; no partial pop completes.
- Flag behaviour: `overrun` and `dropped` are sticky until `clear` or `reset`.
- State changes: `state` output changes on the edge following the triggering input.

## Test plan
- Basic capture: reset, `enable`, then 3 event cycles (rv reg 5=0xDEADBEEF; mw addr 0x10 data 0x11; mr addr 0x20 data 0x22), then `halt` -> state=FROZEN, count=3. Draining with `out_ready`=1 returns flags 100/010/001 in order with ts strictly increasing, then `out_valid`=0.
- Combined event: rv, mw and mr in one cycle (reg 1=0xA, addr 0x4, `wr_data`=0xB, `rd_data`=0xC) -> a single entry with flags 111 and mem_data=0xB.
- Stop-mode full, DEPTH=4, WRAP_MODE=0: 5 events with no pop -> count=4, `dropped`=1, state=FROZEN, and the 4 stored entries are events 1–4.
- Wrap mode, DEPTH=4, WRAP_MODE=1: 6 events with no pop -> count=4, `overrun`=1, state=CAPTURE, and draining yields events 3–6.
- Full with simultaneous push and pop: buffer full, event and pop in the same cycle -> count stays 4, `dropped`=`overrun`=0, and the popped entry is the oldest.
- Reset and clear: async `reset` mid-capture with count=3 -> count=0, state=IDLE and `out_valid`=0 before the next edge. `clear` in FROZEN -> IDLE with flags cleared and ts=0.
